softmax_in_collector: RTL and testbench

Streaming front-end for the combinational softmax block.
- Accepts N signed Q4.12 scores one per beat over a valid/ready stream.
- Tracks the running signed maximum while the scores arrive.
- Presents the assembled in_x_flat vector and max_x to the softmax core, held stable under a valid/ready output handshake until the consumer accepts.
- It is the producer end of the softmax input interface: the softmax core never computes its own max.

---
 rtl/softmax_in_collector_pkg.sv | 14 +
 rtl/softmax_in_collector_if.sv | 27 ++
 rtl/sm_signed_max2.sv | 11 +
 rtl/softmax_in_collector.sv | 105 ++++++++++
 tb/tb_softmax_in_collector.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/softmax_in_collector_pkg.sv
// Shared softmax definitions: Q4.12 score format constants and collector states.
package softmax_in_collector_pkg;

    // Q4.12 signed score format
    localparam int unsigned SM_W       = 16;
    localparam int unsigned SM_FRAC    = 12;
    localparam logic [15:0] SM_NEG_MAX = 16'h8000;

    typedef enum logic {
        COLLECT,
        HOLD
    } sm_state_e;

endpackage

// File: rtl/softmax_in_collector_if.sv
// Score stream in, assembled vector out. The collector takes the slave view.
interface softmax_in_collector_if
    import softmax_in_collector_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = SM_W
);
    logic             s_valid;
    logic             s_ready;
    logic [W-1:0]     s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [N*W-1:0]   in_x_flat;
    logic [W-1:0]     max_x;
    logic             err_len;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, in_x_flat, max_x, err_len
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, in_x_flat, max_x, err_len
    );
endinterface

// File: rtl/sm_signed_max2.sv
// Combinational signed maximum of two W-bit values; a tie returns a.
module sm_signed_max2 #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    // strict compare so an equal b never displaces a
    always_comb y = ($signed(b) > $signed(a)) ? b : a;
endmodule

// File: rtl/softmax_in_collector.sv
// Collects N Q4.12 scores from a stream, tracks their signed max and presents the
// vector plus max to the softmax core under a valid/ready hold.
module softmax_in_collector
    import softmax_in_collector_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned W   = SM_W,
    parameter logic [W-1:0] PAD = W'(SM_NEG_MAX)
) (
    input  logic                  clk,
    input  logic                  rst,
    softmax_in_collector_if.slave bus
);
    localparam int unsigned     CW       = $clog2(N);
    localparam logic [CW-1:0]   LAST_IDX = CW'(N - 1);

    sm_state_e     state, state_next;
    logic [CW-1:0] count, count_next;
    logic [W-1:0]  elem      [N];
    logic [W-1:0]  elem_next [N];
    logic [W-1:0]  max_r, max_next, max_cand;
    logic          err_r, err_next;
    logic          accept;
    logic          at_last_idx;

    assign accept        = bus.s_valid && bus.s_ready;
    assign at_last_idx   = (count == LAST_IDX);
    assign bus.s_ready   = (state == COLLECT);
    assign bus.m_valid   = (state == HOLD);
    assign bus.max_x     = max_r;
    assign bus.err_len   = err_r;

    sm_signed_max2 #(.W(W)) u_max (
        .a(max_r),
        .b(bus.s_data),
        .y(max_cand)
    );

    // Flatten element registers onto the output vector, element 0 in the low bits
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.in_x_flat[W*i +: W] = elem[i];
        end
    end

    // Next-state: store beats, pad short vectors, flag length mismatches
    always_comb begin
        state_next = state;
        count_next = count;
        max_next   = max_r;
        err_next   = 1'b0;
        for (int i = 0; i < N; i++) begin
            elem_next[i] = elem[i];
        end
        unique case (state)
            COLLECT: begin
                if (accept) begin
                    for (int i = 0; i < N; i++) begin
                        if (CW'(i) == count) begin
                            elem_next[i] = bus.s_data;
                        end else if (bus.s_last && (CW'(i) > count)) begin
                            elem_next[i] = PAD;
                        end
                    end
                    // PAD never enters the max; only real beats do
                    max_next = (count == '0) ? bus.s_data : max_cand;
                    if (bus.s_last || at_last_idx) begin
                        state_next = HOLD;
                        count_next = '0;
                        err_next   = (bus.s_last != at_last_idx);
                    end else begin
                        count_next = count + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.m_ready) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // State and datapath registers; reset discards any partial vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
            count <= '0;
            max_r <= '0;
            err_r <= 1'b0;
            for (int i = 0; i < N; i++) begin
                elem[i] <= '0;
            end
        end else begin
            state <= state_next;
            count <= count_next;
            max_r <= max_next;
            err_r <= err_next;
            for (int i = 0; i < N; i++) begin
                elem[i] <= elem_next[i];
            end
        end
    end
endmodule

// File: tb/tb_softmax_in_collector.sv
// Directed self-checking bench for softmax_in_collector (N=4, W=16).
module tb_softmax_in_collector;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    softmax_in_collector_if #(.N(4), .W(16)) bus ();

    softmax_in_collector #(.N(4), .W(16), .PAD(16'h8000)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one accepted beat; returns #1 after the sampling edge
    task automatic beat(input logic [15:0] d, input logic l);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic check_vec(input string tag, input logic [63:0] flat,
                             input logic [15:0] mx, input logic err);
        check({tag, " m_valid"}, 64'(bus.m_valid), 64'd1);
        check({tag, " s_ready"}, 64'(bus.s_ready), 64'd0);
        check({tag, " flat"}, bus.in_x_flat, flat);
        check({tag, " max"}, 64'(bus.max_x), 64'(mx));
        check({tag, " err"}, 64'(bus.err_len), 64'(err));
    endtask

    // accept edge with m_ready high: bubble cycle, err_len must have dropped
    task automatic accept_vec(input string tag);
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " m_valid drop"}, 64'(bus.m_valid), 64'd0);
        check({tag, " s_ready back"}, 64'(bus.s_ready), 64'd1);
        check({tag, " err pulse end"}, 64'(bus.err_len), 64'd0);
    endtask

    initial begin
        logic [63:0] held;
        passed      = 0;
        total       = 0;
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst m_valid", 64'(bus.m_valid), 64'd0);
        check("rst err", 64'(bus.err_len), 64'd0);
        check("rst flat", bus.in_x_flat, 64'd0);
        check("rst max", 64'(bus.max_x), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst s_ready", 64'(bus.s_ready), 64'd1);

        // basic vector; m_valid must be up right after the 4th beat edge
        beat(16'hEC80, 1'b0);
        beat(16'hFE18, 1'b0);
        beat(16'h2771, 1'b0);
        check("basic mid m_valid", 64'(bus.m_valid), 64'd0);
        beat(16'h15DB, 1'b1);
        check_vec("basic", 64'h15DB_2771_FE18_EC80, 16'h2771, 1'b0);
        accept_vec("basic");

        // all negative
        beat(16'h8000, 1'b0);
        beat(16'h8001, 1'b0);
        beat(16'hFFFF, 1'b0);
        beat(16'hC000, 1'b1);
        check_vec("neg", 64'hC000_FFFF_8001_8000, 16'hFFFF, 1'b0);
        accept_vec("neg");

        // tie on the max
        beat(16'h1000, 1'b0);
        beat(16'h1000, 1'b0);
        beat(16'h0000, 1'b0);
        beat(16'hF000, 1'b1);
        check_vec("tie", 64'hF000_0000_1000_1000, 16'h1000, 1'b0);
        accept_vec("tie");

        // early last: padded, max over real elements only
        beat(16'hEC80, 1'b0);
        beat(16'hFE18, 1'b1);
        check_vec("early", 64'h8000_8000_FE18_EC80, 16'hFE18, 1'b1);
        accept_vec("early");

        // missing last, then a properly terminated vector
        beat(16'h0001, 1'b0);
        beat(16'h0002, 1'b0);
        beat(16'h0003, 1'b0);
        beat(16'h0004, 1'b0);
        check_vec("miss1", 64'h0004_0003_0002_0001, 16'h0004, 1'b1);
        accept_vec("miss1");
        beat(16'h0005, 1'b0);
        beat(16'h0006, 1'b0);
        beat(16'h0007, 1'b0);
        beat(16'h0008, 1'b1);
        check_vec("miss2", 64'h0008_0007_0006_0005, 16'h0008, 1'b0);
        accept_vec("miss2");

        // backpressure with s_valid held high throughout
        bus.m_ready = 1'b0;
        beat(16'h1111, 1'b0);
        beat(16'h2222, 1'b0);
        beat(16'h3333, 1'b0);
        beat(16'h4444, 1'b1);
        held        = 64'h4444_3333_2222_1111;
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h7777;
        bus.s_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp s_ready", 64'(bus.s_ready), 64'd0);
            check("bp m_valid", 64'(bus.m_valid), 64'd1);
            check("bp flat", bus.in_x_flat, held);
            check("bp max", 64'(bus.max_x), 64'h4444);
        end
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        check("bp release m_valid", 64'(bus.m_valid), 64'd0);
        check("bp release s_ready", 64'(bus.s_ready), 64'd1);
        // had 0x7777 been swallowed it would sit in element 0
        beat(16'h0AAA, 1'b0);
        beat(16'h0BBB, 1'b1);
        check_vec("bp after", 64'h8000_8000_0BBB_0AAA, 16'h0BBB, 1'b1);
        accept_vec("bp after");

        // reset while holding a vector: m_valid drops asynchronously
        bus.m_ready = 1'b0;
        beat(16'h0010, 1'b0);
        beat(16'h0020, 1'b0);
        beat(16'h0030, 1'b0);
        beat(16'h0040, 1'b1);
        check("hold before rst", 64'(bus.m_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst hold m_valid", 64'(bus.m_valid), 64'd0);
        check("rst hold flat", bus.in_x_flat, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.m_ready = 1'b1;

        // reset mid-collect: the partial vector must leave nothing behind
        beat(16'h1234, 1'b0);
        beat(16'h5678, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("rst mid m_valid", 64'(bus.m_valid), 64'd0);
        check("rst mid flat", bus.in_x_flat, 64'd0);
        check("rst mid max", 64'(bus.max_x), 64'd0);
        check("rst mid err", 64'(bus.err_len), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        beat(16'h0100, 1'b0);
        beat(16'h0200, 1'b0);
        beat(16'h0300, 1'b0);
        check("post rst no early end", 64'(bus.m_valid), 64'd0);
        beat(16'h0400, 1'b1);
        check_vec("post rst", 64'h0400_0300_0200_0100, 16'h0400, 1'b0);
        accept_vec("post rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
